// File: rtl/sumador_serie_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package sumador_serie_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_RUN_ENC  = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    RUN  = ST_RUN_ENC,
    DONE = ST_DONE_ENC
  } state_t;

  // Counter must index bits 0..width-1; clamp so a degenerate width never yields 0 bits.
  function automatic int cnt_width(input int width);
    if (width < 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage : sumador_serie_pkg

// File: rtl/sumador_serie_if.sv
// Request/result bundle for sumador_serie; master = requester, slave = adder.
interface sumador_serie_if #(
  parameter int WIDTH = 8
);

  // start_i is a level request sampled only while the adder is idle (busy_o low);
  // it is accepted on that edge together with a_i/b_i/c_i, and the result is
  // valid from the single cycle done_o is high until the next completion.
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
  logic [1:0]       dbg_state_o;

  modport master (
    output start_i,
    output a_i,
    output b_i,
    output c_i,
    input  busy_o,
    input  done_o,
    input  s_o,
    input  c_o,
    input  dbg_state_o
  );

  modport slave (
    input  start_i,
    input  a_i,
    input  b_i,
    input  c_i,
    output busy_o,
    output done_o,
    output s_o,
    output c_o,
    output dbg_state_o
  );

endinterface : sumador_serie_if

// File: rtl/sumador_serie_sumador1.sv
// One-bit full adder: the only arithmetic element reused every cycle by sumador_serie.
module sumador1 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule : sumador1

// File: rtl/sumador_serie.sv
// Bit-serial adder: one full adder walks the operands LSB first over WIDTH cycles.
module sumador_serie
  import sumador_serie_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  sumador_serie_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_next;

  sumador1 u_sumador1 (
    .a_i (r_a[0]),
    .b_i (r_b[0]),
    .c_i (r_carry),
    .s_o (w_sum),
    .c_o (w_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
  assign w_sum_next = {w_sum, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_a     <= bus.a_i;
            r_b     <= bus.b_i;
            r_carry <= bus.c_i;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_s     <= w_sum_next;
            r_c     <= w_cout;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.s_o         = r_s;
  assign bus.c_o         = r_c;
  assign bus.dbg_state_o = r_state;

endmodule : sumador_serie

// File: tb/tb_sumador_serie.sv
// Directed and random checks of sumador_serie at WIDTH=8 and WIDTH=16.
module tb_sumador_serie;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sumador_serie_if #(.WIDTH(8))  bus8();
  sumador_serie_if #(.WIDTH(16)) bus16();

  sumador_serie #(.WIDTH(8)) dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus8)
  );

  sumador_serie #(.WIDTH(16)) dut16 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one 8-bit operation, measuring done latency and busy cycles
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] s, output logic co,
                     output int lat, output int busy_n, output bit ok);
    s = '0; co = 1'b0; lat = -1; busy_n = 0; ok = 1'b0;
    bus8.start_i = 1'b1; bus8.a_i = a; bus8.b_i = b; bus8.c_i = c;
    @(posedge clk); #1;
    bus8.start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus8.busy_o) busy_n++;
      if (bus8.done_o && !ok) begin
        ok = 1'b1; lat = k; s = bus8.s_o; co = bus8.c_o;
      end
      if (ok && !bus8.busy_o) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      output logic [15:0] s, output logic co, output bit ok);
    s = '0; co = 1'b0; ok = 1'b0;
    bus16.start_i = 1'b1; bus16.a_i = a; bus16.b_i = b; bus16.c_i = c;
    @(posedge clk); #1;
    bus16.start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus16.done_o && !ok) begin
        ok = 1'b1; s = bus16.s_o; co = bus16.c_o;
      end
      if (ok && !bus16.busy_o) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start_i = 1'b0;  bus8.a_i = '0;  bus8.b_i = '0;  bus8.c_i = 1'b0;
    bus16.start_i = 1'b0; bus16.a_i = '0; bus16.b_i = '0; bus16.c_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus8.busy_o, bus8.done_o, bus8.c_o, bus8.s_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b c=%b s=%h, want all 0",
               bus8.busy_o, bus8.done_o, bus8.c_o, bus8.s_o);
    end
    n_tests++;
    if ({bus16.busy_o, bus16.done_o, bus16.c_o, bus16.s_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset16: got busy=%b done=%b c=%b s=%h, want all 0",
               bus16.busy_o, bus16.done_o, bus16.c_o, bus16.s_o);
    end
    n_tests++;
    if (bus8.dbg_state_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 00", bus8.dbg_state_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co; int lat; int busy_n; bit ok;
    op8(8'h3C, 8'h0F, 1'b0, s, co, lat, busy_n, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done: no done pulse within bound"); end
    n_tests++;
    if ({co, s} !== 9'h04B) begin
      n_fail++; $display("FAIL basic_sum: got c=%b s=%h want c=0 s=4b", co, s);
    end
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_tests++;
    if (busy_n !== 9) begin n_fail++; $display("FAIL basic_busy: got %0d cycles want 9", busy_n); end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic co; int lat; int busy_n; bit ok;
    op8(8'hFF, 8'h01, 1'b0, s, co, lat, busy_n, ok);
    n_tests++;
    if (!ok || {co, s} !== 9'h100) begin
      n_fail++; $display("FAIL carry_ripple: got ok=%b c=%b s=%h want c=1 s=00", ok, co, s);
    end
    op8(8'hFF, 8'hFF, 1'b1, s, co, lat, busy_n, ok);
    n_tests++;
    if (!ok || {co, s} !== 9'h1FF) begin
      n_fail++; $display("FAIL carry_all_ones: got ok=%b c=%b s=%h want c=1 s=ff", ok, co, s);
    end
  endtask

  task automatic test_back_to_back();
    int npulse; int prev;
    bus8.start_i = 1'b1; bus8.a_i = 8'h12; bus8.b_i = 8'h34; bus8.c_i = 1'b0;
    @(posedge clk); #1;
    npulse = 0; prev = -1;
    for (int k = 0; k < 36; k++) begin
      if (k == 2) begin bus8.a_i = 8'hAA; bus8.b_i = 8'h55; end
      if (bus8.done_o) begin
        npulse++;
        if (npulse == 1) begin
          n_tests++;
          if (k != 8 || bus8.s_o !== 8'h46 || bus8.c_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got cycle=%0d s=%h c=%b want cycle=8 s=46 c=0", k, bus8.s_o, bus8.c_o);
          end
        end else begin
          n_tests++;
          if (k - prev != 10 || bus8.s_o !== 8'hFF || bus8.c_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_next: got period=%0d s=%h c=%b want period=10 s=ff c=0", k - prev, bus8.s_o, bus8.c_o);
          end
        end
        prev = k;
      end
      @(posedge clk); #1;
    end
    bus8.start_i = 1'b0;
    n_tests++;
    if (npulse != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", npulse); end
    for (int k = 0; k < 20 && bus8.busy_o; k++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: busy still %b want 0", bus8.busy_o); end
  endtask

  task automatic test_ignore_start();
    int npulse; int pk; logic [7:0] ps;
    bus8.start_i = 1'b1; bus8.a_i = 8'h10; bus8.b_i = 8'h20; bus8.c_i = 1'b0;
    @(posedge clk); #1;
    bus8.start_i = 1'b0;
    npulse = 0; pk = -1; ps = '0;
    for (int k = 0; k < 21; k++) begin
      if (bus8.done_o) begin npulse++; pk = k; ps = bus8.s_o; end
      bus8.start_i = 1'b0;
      if (k == 3) begin bus8.start_i = 1'b1; bus8.a_i = 8'h77; bus8.b_i = 8'h11; end
      if (k == 8) begin bus8.start_i = 1'b1; bus8.a_i = 8'h99; bus8.b_i = 8'h01; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (npulse != 1 || pk != 8) begin
      n_fail++; $display("FAIL ignore_pulses: got %0d pulses (last cycle %0d) want 1 at 8", npulse, pk);
    end
    n_tests++;
    if (ps !== 8'h30 || bus8.s_o !== 8'h30) begin
      n_fail++; $display("FAIL ignore_sum: got pulse s=%h hold s=%h want 30", ps, bus8.s_o);
    end
    n_tests++;
    if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_queued: busy=%b want 0", bus8.busy_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s; logic co; int lat; int busy_n; bit ok; int npulse;
    bus8.start_i = 1'b1; bus8.a_i = 8'h55; bus8.b_i = 8'h66; bus8.c_i = 1'b0;
    @(posedge clk); #1;
    bus8.start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus8.busy_o, bus8.done_o, bus8.c_o, bus8.s_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: got busy=%b done=%b c=%b s=%h want all 0",
               bus8.busy_o, bus8.done_o, bus8.c_o, bus8.s_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.done_o || bus8.busy_o) npulse++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (npulse != 0 || bus8.s_o !== 8'h00) begin
      n_fail++; $display("FAIL midreset_abort: got %0d active cycles s=%h want 0 and 00", npulse, bus8.s_o);
    end
    op8(8'h55, 8'h66, 1'b0, s, co, lat, busy_n, ok);
    n_tests++;
    if (!ok || {co, s} !== 9'h0BB || lat != 8) begin
      n_fail++; $display("FAIL midreset_next: got ok=%b c=%b s=%h lat=%0d want c=0 s=bb lat=8", ok, co, s, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] a8, b8, s8; logic [15:0] a16, b16, s16;
    logic c, co; int lat; int busy_n; bit ok;
    logic [8:0] exp9; logic [16:0] exp17;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
      exp9 = 9'(a8) + 9'(b8) + 9'(c);
      op8(a8, b8, c, s8, co, lat, busy_n, ok);
      n_tests++;
      if (!ok || {co, s8} !== exp9) begin
        n_fail++; $display("FAIL rand8: %h+%h+%b got ok=%b %h want %h", a8, b8, c, ok, {co, s8}, exp9);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom_range(0, 65535)); b16 = 16'($urandom_range(0, 65535)); c = 1'($urandom_range(0, 1));
      exp17 = 17'(a16) + 17'(b16) + 17'(c);
      op16(a16, b16, c, s16, co, ok);
      n_tests++;
      if (!ok || {co, s16} !== exp17) begin
        n_fail++; $display("FAIL rand16: %h+%h+%b got ok=%b %h want %h", a16, b16, c, ok, {co, s16}, exp17);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sumador_serie

// File: doc/sumador_serie.md
# sumador_serie

Bit-serial adder controller that sequences a single one-bit full adder over WIDTH clock cycles to add two WIDTH-bit operands. It accepts a start request, captures the operands, feeds one bit pair per cycle (LSB first) into the one-bit adder, and recirculates the carry through a register. It then presents the sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a ripple-carry chain.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range is 2 to 32.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- start_i  in  1  request to begin an addition; sampled only in IDLE.
- a_i  in  WIDTH  operand A; captured on the edge that accepts start_i.
- b_i  in  WIDTH  operand B; captured on the same edge.
- c_i  in  1  carry-in; captured on the same edge.
- busy_o  out  1  high while state is RUN or DONE.
- done_o  out  1  one-cycle pulse; high while state is DONE.
- s_o  out  WIDTH  registered sum of the last completed operation.
- c_o  out  1  registered carry-out of the last completed operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1: load shift registers A←a_i, B←b_i; carry register ←c_i; bit counter ←0; sum shift register ←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (one bit per edge):
  - Adder inputs are A[0], B[0] and the carry register.
  - A and B shift right by one.
  - The adder sum bit enters the sum shift register at the MSB, and the register shifts right.
  - Carry register ← adder carry-out.
  - Counter increments.
  - When counter = WIDTH-1 on an edge, that edge also copies the final sum-shift value to s_o and the final carry to c_o, then goes to DONE.
- DONE: done_o=1; go to IDLE on the next edge unconditionally.
- s_o and c_o change only on the RUN→DONE edge. They are stable during RUN and hold until the next completion.
- start_i asserted in RUN or DONE is ignored. It is not queued.
- Arithmetic is modulo 2^WIDTH, and c_o is bit WIDTH of a_i+b_i+c_i.
- Reset (rst_ni=0, at any time including mid-RUN):
  - State → IDLE.
  - s_o, c_o, busy_o, done_o all go to 0.
  - Shift registers, carry register and counter all go to 0.
  - An aborted operation produces no done_o pulse and no result update.

## Timing
- Reset values: every output is 0.
- Start is accepted on edge E0. Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- done_o is high for exactly the cycle between edge EWIDTH and edge EWIDTH+1. s_o and c_o are valid from that cycle onward.
- busy_o rises after E0 and falls after EWIDTH+1.
- If start_i is held high continuously, a new operation is accepted every WIDTH+2 cycles: at E0, then at EWIDTH+2.
- Combinational path per cycle: one full adder from the register LSBs to the carry and sum registers.
- No outputs are driven combinationally from inputs.

## Structure
- Shared package/include:
  - State encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - A helper for the counter width, $clog2(WIDTH).
- One sub-module: an instance of sumador1, the one-bit full adder, wired as:
  - a_i←A[0], b_i←B[0], c_i←carry register.
  - s_o→sum shift input, c_o→carry register D input.
- The FSM, counter and shift registers live in sumador_serie. There is no further hierarchy.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h0F, c_i=0 → s_o=8'h4B, c_o=0. done_o pulses exactly 8 clocks after the start edge, and busy_o is high for 9 cycles.
- a=8'hFF, b=8'h01, c_i=0 → s_o=8'h00, c_o=1 (full carry ripple). Then a=8'hFF, b=8'hFF, c_i=1 → s_o=8'hFF, c_o=1.
- Hold start_i=1 permanently with fixed operands → done_o pulses every 10 cycles. Change a_i and b_i during RUN → the result reflects only the captured values.
- Assert start_i with different operands during RUN and during DONE → ignored. The result matches the first operation, and no extra done_o pulse occurs.
- Drop rst_ni for one cycle at bit 4 of a RUN → all outputs go to 0 immediately, no done_o pulse follows, and the previous s_o is cleared. The next start completes correctly.
- Random regression: 1000 random a, b and c_i at WIDTH=8 and WIDTH=16 → {c_o,s_o} equals a+b+c_i for each done_o pulse.
